// File: rtl/imem_loader.sv
// Boot loader for the instruction RAM: turns a framed UART byte stream into big-endian word writes and holds the CPU until the image is complete.
// Define IMEM_LOADER_CKSUM_EN to require a trailing 8-bit payload checksum byte.
module imem_loader #(
  parameter logic [31:0] BASE_ADDR      = 32'h0000_0000,
  parameter int          WORD_LIMIT     = 32,
  parameter int          TIMEOUT_CYCLES = 100000
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [7:0]  rx_data,
  input  logic        rx_valid,
  input  logic        start,
  output logic        wr_en,
  output logic [31:0] wr_addr,
  output logic [31:0] wr_data,
  output logic        cpu_hold,
  output logic        done,
  output logic [1:0]  err_code
);

  localparam logic [2:0] S_IDLE   = 3'd0;
  localparam logic [2:0] S_LEN_LO = 3'd1;
  localparam logic [2:0] S_DATA   = 3'd2;
  localparam logic [2:0] S_DONE   = 3'd4;
  localparam logic [2:0] S_ERR    = 3'd5;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam logic [2:0] S_CKSUM       = 3'd3;
  localparam logic [2:0] S_PAYLOAD_END = S_CKSUM;
  localparam logic [1:0] ERR_CKSUM     = 2'd3;
`else
  localparam logic [2:0] S_PAYLOAD_END = S_DONE;
`endif

  localparam logic [1:0] ERR_NONE    = 2'd0;
  localparam logic [1:0] ERR_LEN     = 2'd1;
  localparam logic [1:0] ERR_TIMEOUT = 2'd2;

  // The gap counter only has to count up to TIMEOUT_CYCLES-1; the next idle cycle is the timeout.
  localparam int               GAP_W    = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'(TIMEOUT_CYCLES - 1);

  logic [2:0]       state;
  logic [7:0]       len_hi;
  logic [15:0]      word_total;
  logic [15:0]      word_cnt;
  logic [1:0]       byte_cnt;
  logic [GAP_W-1:0] gap_cnt;
  logic [15:0]      len_now;
  logic             in_frame;
  logic             timed_out;
  logic             rearm;
`ifdef IMEM_LOADER_CKSUM_EN
  logic [7:0]       sum;

  assign in_frame = (state == S_LEN_LO) || (state == S_DATA) || (state == S_CKSUM);
`else
  assign in_frame = (state == S_LEN_LO) || (state == S_DATA);
`endif

  assign len_now   = {len_hi, rx_data};
  assign timed_out = in_frame && !rx_valid && (gap_cnt == GAP_LAST);
  // start re-arms only from a terminal state, and then wins over a same-cycle byte.
  assign rearm     = start && ((state == S_DONE) || (state == S_ERR));

  assign done     = (state == S_DONE);
  assign cpu_hold = (state != S_DONE);

  // NOTE: all state updates are non-blocking so every register samples pre-edge values,
  // which is what lets a word's write strobe and the next byte's shift share an edge safely.
  always_ff @(posedge clk) begin
    if (reset || rearm) begin
      state      <= S_IDLE;
      wr_en      <= 1'b0;
      wr_addr    <= BASE_ADDR;
      wr_data    <= '0;
      err_code   <= ERR_NONE;
      len_hi     <= '0;
      word_total <= '0;
      word_cnt   <= '0;
      byte_cnt   <= '0;
      gap_cnt    <= '0;
`ifdef IMEM_LOADER_CKSUM_EN
      sum        <= '0;
`endif
    end else begin
      wr_en <= 1'b0;
      if (wr_en) wr_addr <= wr_addr + 32'd4;
      if (in_frame) gap_cnt <= rx_valid ? '0 : gap_cnt + GAP_W'(1);

      if (timed_out) begin
        state    <= S_ERR;
        err_code <= ERR_TIMEOUT;
      end else if (rx_valid) begin
        case (state)
          S_IDLE: begin
            len_hi <= rx_data;
            state  <= S_LEN_LO;
          end
          S_LEN_LO: begin
            word_total <= len_now;
            if ({16'd0, len_now} > $unsigned(WORD_LIMIT)) begin
              state    <= S_ERR;
              err_code <= ERR_LEN;
            end else if (len_now == 16'd0) begin
              state <= S_PAYLOAD_END;
            end else begin
              state <= S_DATA;
            end
          end
          S_DATA: begin
            wr_data  <= {wr_data[23:0], rx_data};
            byte_cnt <= byte_cnt + 2'd1;
`ifdef IMEM_LOADER_CKSUM_EN
            sum      <= sum + rx_data;
`endif
            if (byte_cnt == 2'd3) begin
              wr_en    <= 1'b1;
              word_cnt <= word_cnt + 16'd1;
              if (word_cnt + 16'd1 == word_total) state <= S_PAYLOAD_END;
            end
          end
`ifdef IMEM_LOADER_CKSUM_EN
          S_CKSUM: begin
            if (rx_data == sum) begin
              state <= S_DONE;
            end else begin
              state    <= S_ERR;
              err_code <= ERR_CKSUM;
            end
          end
`endif
          default: ; // DONE and ERR drop every byte
        endcase
      end
    end
  end

endmodule

// File: tb/tb_imem_loader.sv
// Randomized bench for imem_loader: a frame-position reference model predicts every output each cycle,
// with directed frames whose writes and status are pinned to hand-computed literals.
module tb_imem_loader;

  localparam logic [31:0] BASE  = 32'h0000_0000;
  localparam int          LIMIT = 32;
  localparam int          TMO   = 16;
`ifdef IMEM_LOADER_CKSUM_EN
  localparam bit CK = 1'b1;
`else
  localparam bit CK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset;
  logic [7:0]  rx_data;
  logic        rx_valid;
  logic        start;
  logic        wr_en;
  logic [31:0] wr_addr;
  logic [31:0] wr_data;
  logic        cpu_hold;
  logic        done;
  logic [1:0]  err_code;

  imem_loader #(.BASE_ADDR(BASE), .WORD_LIMIT(LIMIT), .TIMEOUT_CYCLES(TMO)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid), .start(start),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .cpu_hold(cpu_hold), .done(done), .err_code(err_code)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", name, got, exp, $time);
    end
  endtask

  // Reference model: tracks the frame as a list of accepted bytes and derives outputs from byte positions.
  typedef enum {M_LOAD, M_DONE, M_ERR} phase_t;
  phase_t      m_phase;
  logic [7:0]  frame[$];
  int          m_n;
  int          m_gap;
  bit          model_live = 1'b0;
  logic        exp_wr_en;
  logic [31:0] exp_wr_addr;
  logic [31:0] exp_wr_data;
  logic [1:0]  exp_err;

  function automatic void m_clear();
    m_phase     = M_LOAD;
    frame.delete();
    m_n         = 0;
    m_gap       = 0;
    exp_wr_en   = 1'b0;
    exp_wr_addr = BASE;
    exp_wr_data = '0;
    exp_err     = 2'd0;
  endfunction

  function automatic logic [7:0] cks(input logic [7:0] q[$]);
    logic [7:0] s = 8'h00;
    for (int i = 2; i < q.size(); i++) s = s + q[i];
    return s;
  endfunction

  function automatic void m_payload_end();
    if (!CK) m_phase = M_DONE;
  endfunction

  function automatic void m_accept(input logic [7:0] b);
    int p;
    m_gap = 0;
    frame.push_back(b);
    p = frame.size();
    if (p == 2) begin
      m_n = int'({frame[0], frame[1]});
      if (m_n > LIMIT) begin
        m_phase = M_ERR;
        exp_err = 2'd1;
      end else if (m_n == 0) begin
        m_payload_end();
      end
    end else if (p > 2 && p <= 2 + 4 * m_n) begin
      if ((p - 2) % 4 == 0) begin
        exp_wr_en   = 1'b1;
        exp_wr_data = {frame[p-4], frame[p-3], frame[p-2], frame[p-1]};
      end
      if (p == 2 + 4 * m_n) m_payload_end();
    end else if (p == 3 + 4 * m_n) begin
      logic [7:0] pay[$];
      pay = frame[0:p-2];
      if (cks(pay) == b) m_phase = M_DONE;
      else begin
        m_phase = M_ERR;
        exp_err = 2'd3;
      end
    end
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      m_clear();
      model_live = 1'b1;
    end else if (model_live) begin
      if (exp_wr_en) exp_wr_addr = exp_wr_addr + 32'd4;
      exp_wr_en = 1'b0;
      if (m_phase != M_LOAD) begin
        if (start) m_clear();
      end else if (rx_valid) begin
        m_accept(rx_data);
      end else if (frame.size() > 0) begin
        m_gap++;
        if (m_gap == TMO) begin
          m_phase = M_ERR;
          exp_err = 2'd2;
        end
      end
    end
  end

  logic [31:0] obs_addr[$];
  logic [31:0] obs_data[$];

  always @(negedge clk) begin
    if (model_live) begin
      check("wr_en", 32'(wr_en), 32'(exp_wr_en));
      check("wr_addr", wr_addr, exp_wr_addr);
      if (exp_wr_en) check("wr_data", wr_data, exp_wr_data);
      check("done", 32'(done), 32'(m_phase == M_DONE));
      check("cpu_hold", 32'(cpu_hold), 32'(m_phase != M_DONE));
      check("err_code", 32'(err_code), 32'(exp_err));
      if (wr_en === 1'b1) begin
        obs_addr.push_back(wr_addr);
        obs_data.push_back(wr_data);
      end
    end
  end

  function automatic logic [31:0] qat(input logic [31:0] q[$], input int i);
    return (i < q.size()) ? q[i] : 32'hxxxx_xxxx;
  endfunction

  // All stimulus tasks start and end just after a falling edge.
  task automatic idle(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    @(negedge clk);
    rx_valid = 1'b0;
  endtask

  task automatic send_seq(input logic [7:0] s[$], input int max_gap);
    foreach (s[i]) begin
      send(s[i]);
      if (i + 1 < s.size()) begin
        repeat ($urandom_range(0, max_gap)) begin
          start = ($urandom_range(0, 9) == 0);
          @(negedge clk);
          start = 1'b0;
        end
      end
    end
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic fresh();
    do_reset();
    idle(1);
    obs_addr.delete();
    obs_data.delete();
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [7:0] s[$];
    int k;
    reset = 1'b1; rx_valid = 1'b0; start = 1'b0; rx_data = 8'h00;
    @(negedge clk);
    check("rst_wr_en", 32'(wr_en), 32'd0);
    check("rst_wr_addr", wr_addr, BASE);
    check("rst_wr_data", wr_data, 32'd0);
    check("rst_hold", 32'(cpu_hold), 32'd1);
    check("rst_done", 32'(done), 32'd0);
    check("rst_err", 32'(err_code), 32'd0);
    reset = 1'b0;

    // Two-word image, checksum 6C when enabled.
    fresh();
    s = {8'h00, 8'h02, 8'h20, 8'h04, 8'h30, 8'h39, 8'hAF, 8'h24, 8'h00, 8'h0C};
    if (CK) s.push_back(8'h6C);
    send_seq(s, 0);
    check("t1_done_next", 32'(done), 32'd1);
    idle(2);
    check("t1_nwr", obs_data.size(), 32'd2);
    check("t1_d0", qat(obs_data, 0), 32'h2004_3039);
    check("t1_a0", qat(obs_addr, 0), 32'h0000_0000);
    check("t1_d1", qat(obs_data, 1), 32'hAF24_000C);
    check("t1_a1", qat(obs_addr, 1), 32'h0000_0004);
    check("t1_hold", 32'(cpu_hold), 32'd0);
    check("t1_err", 32'(err_code), 32'd0);
    check("t1_model", 32'(m_phase == M_DONE), 32'd1);

`ifdef IMEM_LOADER_CKSUM_EN
    fresh();
    s = {8'h00, 8'h02, 8'h20, 8'h04, 8'h30, 8'h39, 8'hAF, 8'h24, 8'h00, 8'h0C, 8'h6D};
    send_seq(s, 1);
    idle(2);
    check("t2_nwr", obs_data.size(), 32'd2);
    check("t2_err", 32'(err_code), 32'd3);
    check("t2_hold", 32'(cpu_hold), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check("t2_model", 32'(exp_err), 32'd3);
`endif

    // Length 33 exceeds a 32-word RAM.
    fresh();
    send(8'h00);
    send(8'h21);
    check("t3_err", 32'(err_code), 32'd1);
    send_seq({8'h11, 8'h22, 8'h33, 8'h44}, 0);
    idle(2);
    check("t3_nwr", obs_data.size(), 32'd0);
    check("t3_err_held", 32'(err_code), 32'd1);

    // Truncated frame: the 16th idle cycle raises the timeout.
    fresh();
    send_seq({8'h00, 8'h01, 8'h20, 8'h04}, 0);
    k = 0;
    while (k < 40 && err_code !== 2'd2) begin
      @(negedge clk);
      k++;
    end
    check("t4_idle_cycles", k, 32'd16);
    check("t4_nwr", obs_data.size(), 32'd0);
    check("t4_hold", 32'(cpu_hold), 32'd1);
    pulse_start();
    check("t4_err_clr", 32'(err_code), 32'd0);
    check("t4_hold_after", 32'(cpu_hold), 32'd1);

    // Empty image back to back, then start collides with a byte.
    fresh();
    s = {8'h00, 8'h00};
    if (CK) s.push_back(8'h00);
    send_seq(s, 0);
    check("t5_done", 32'(done), 32'd1);
    check("t5_nwr", obs_data.size(), 32'd0);
    start = 1'b1; rx_valid = 1'b1; rx_data = 8'h00;
    @(negedge clk);
    start = 1'b0; rx_valid = 1'b0;
    check("t5_done_clr", 32'(done), 32'd0);
    check("t5_hold", 32'(cpu_hold), 32'd1);
    s = {8'h00, 8'h01, 8'hDE, 8'hAD, 8'hBE, 8'hEF};
    if (CK) s.push_back(8'h38);
    send_seq(s, 0);
    idle(2);
    check("t5_nwr2", obs_data.size(), 32'd1);
    check("t5_d0", qat(obs_data, 0), 32'hDEAD_BEEF);
    check("t5_done2", 32'(done), 32'd1);

    // Reset after the 3rd payload byte, then a clean one-word frame.
    fresh();
    send_seq({8'h00, 8'h01, 8'h11, 8'h22, 8'h33}, 0);
    do_reset();
    check("t6_wr_en", 32'(wr_en), 32'd0);
    check("t6_addr", wr_addr, BASE);
    check("t6_hold", 32'(cpu_hold), 32'd1);
    s = {8'h00, 8'h01, 8'hCA, 8'hFE, 8'hBA, 8'hBE};
    if (CK) s.push_back(8'h40);
    send_seq(s, 0);
    idle(2);
    check("t6_nwr", obs_data.size(), 32'd1);
    check("t6_d0", qat(obs_data, 0), 32'hCAFE_BABE);
    check("t6_a0", qat(obs_addr, 0), BASE);

    // Randomized frames; the per-cycle compare does the checking.
    for (int f = 0; f < 150; f++) begin
      int n, r, cut;
      if (m_phase != M_LOAD) begin
        if ($urandom_range(0, 2) == 0) send($urandom_range(0, 255));
        if ($urandom_range(0, 3) == 0) begin
          start = 1'b1; rx_valid = 1'b1; rx_data = 8'($urandom_range(0, 255));
          @(negedge clk);
          start = 1'b0; rx_valid = 1'b0;
        end else begin
          pulse_start();
        end
      end else begin
        do_reset();
      end
      idle(($urandom_range(0, 7) == 0) ? 25 : $urandom_range(0, 3));

      r = $urandom_range(0, 9);
      if (r < 7)       n = $urandom_range(0, 6);
      else if (r == 7) n = $urandom_range(LIMIT - 1, LIMIT);
      else if (r == 8) n = $urandom_range(LIMIT + 1, 300);
      else             n = $urandom_range(1, 4);
      s = {8'(n >> 8), 8'(n)};
      for (int i = 0; i < 4 * ((r == 8) ? 1 : n); i++) s.push_back(8'($urandom_range(0, 255)));
      if (CK && r != 8) s.push_back(cks(s) ^ (($urandom_range(0, 4) == 0) ? 8'h5A : 8'h00));

      if (r == 9) begin
        cut = $urandom_range(1, s.size() - 1);
        s = s[0:cut-1];
      end
      send_seq(s, $urandom_range(0, 3));
      if (r == 9) begin
        if ($urandom_range(0, 1) == 0) do_reset();
        else idle(TMO + 3);
      end
      idle(2);
    end

    idle(3);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
